// File: rtl/acq_scheduler.sv
// rtl/acq_scheduler.sv - ADC read sequencer and two-channel signed result integrator
module acq_scheduler #(
  parameter int CHANNEL_DATA_WIDTH = 18,
  parameter int SAMPLES_PER_PERIOD = 32,
  parameter int PERIODS_PER_RESULT = 32,
  parameter int COUNT_WIDTH        = 10,
  parameter int RESULT_WIDTH       = 28,
  parameter int TIMEOUT_CYCLES     = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          sample_tick,
  input  logic                          clr_flags,
  output logic                          rd_start,
  input  logic                          rd_done,
  input  logic [CHANNEL_DATA_WIDTH-1:0] rd_data_1,
  input  logic [CHANNEL_DATA_WIDTH-1:0] rd_data_2,
  output logic [RESULT_WIDTH-1:0]       result_1,
  output logic [RESULT_WIDTH-1:0]       result_2,
  output logic                          result_valid,
  output logic                          period_done,
  output logic                          busy,
  output logic                          overrun,
  output logic                          timeout
);

  localparam int TOTAL     = SAMPLES_PER_PERIOD * PERIODS_PER_RESULT;
  localparam int TMO_WIDTH = 8;
  localparam int EXT       = RESULT_WIDTH - CHANNEL_DATA_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] LAST_SAMPLE = COUNT_WIDTH'(TOTAL - 1);
  localparam logic [TMO_WIDTH-1:0]   TMO_LAST    = TMO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]            SPP         = 32'(SAMPLES_PER_PERIOD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_START,
    S_WAIT_DONE,
    S_ACCUM,
    S_PUBLISH
  } state_t;

  state_t state, state_nx;

  logic [TMO_WIDTH-1:0]    tmo_cnt;
  logic [COUNT_WIDTH-1:0]  sample_cnt;
  logic [RESULT_WIDTH-1:0] acc_1, acc_2;
  logic [RESULT_WIDTH-1:0] cap_1, cap_2;
  logic [RESULT_WIDTH-1:0] sum_1, sum_2;

  logic take_sample;
  logic tmo_hit;
  logic last_sample;
  logic period_end;
  logic tick_bad;

  // Decode conditions shared by the FSM, datapath and flag logic
  always_comb begin
    take_sample = (state == S_WAIT_DONE) && rd_done;
    tmo_hit     = (state == S_WAIT_DONE) && !rd_done && (tmo_cnt == TMO_LAST);
    last_sample = (sample_cnt == LAST_SAMPLE);
    period_end  = ((32'(sample_cnt) + 32'd1) % SPP) == 32'd0;
    tick_bad    = sample_tick && (state != S_IDLE) && (state != S_WAIT_TICK);
    sum_1       = acc_1 + cap_1;
    sum_2       = acc_2 + cap_2;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: one read per accepted tick, publish after the last sample
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (enable) state_nx = S_WAIT_TICK;
      S_WAIT_TICK: begin
        if (!enable)          state_nx = S_IDLE;
        else if (sample_tick) state_nx = S_START;
      end
      S_START:     state_nx = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (rd_done)      state_nx = S_ACCUM;
        else if (tmo_hit) state_nx = S_WAIT_TICK;
      end
      S_ACCUM:     state_nx = last_sample ? S_PUBLISH : S_WAIT_TICK;
      S_PUBLISH:   state_nx = S_WAIT_TICK;
      default:     state_nx = S_IDLE;
    endcase
  end

  // Datapath: timeout counter, sample capture, accumulation and result load
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt    <= '0;
      sample_cnt <= '0;
      acc_1      <= '0;
      acc_2      <= '0;
      cap_1      <= '0;
      cap_2      <= '0;
      result_1   <= '0;
      result_2   <= '0;
    end else begin
      case (state)
        S_WAIT_TICK: begin
          if (!enable) begin
            acc_1      <= '0;
            acc_2      <= '0;
            sample_cnt <= '0;
          end
        end
        S_START: tmo_cnt <= '0;
        S_WAIT_DONE: begin
          if (rd_done) begin
            cap_1 <= {{EXT{rd_data_1[CHANNEL_DATA_WIDTH-1]}}, rd_data_1};
            cap_2 <= {{EXT{rd_data_2[CHANNEL_DATA_WIDTH-1]}}, rd_data_2};
          end else begin
            tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);
          end
        end
        S_ACCUM: begin
          if (last_sample) begin
            result_1   <= sum_1;
            result_2   <= sum_2;
            acc_1      <= '0;
            acc_2      <= '0;
            sample_cnt <= '0;
          end else begin
            acc_1      <= sum_1;
            acc_2      <= sum_2;
            sample_cnt <= sample_cnt + COUNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Registered strobes, busy and sticky flags (a set wins over a clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_start     <= 1'b0;
      busy         <= 1'b0;
      period_done  <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      rd_start     <= (state_nx == S_START);
      busy         <= (state_nx != S_IDLE);
      period_done  <= take_sample && period_end;
      result_valid <= (state_nx == S_PUBLISH);
      if (tick_bad)       overrun <= 1'b1;
      else if (clr_flags) overrun <= 1'b0;
      if (tmo_hit)        timeout <= 1'b1;
      else if (clr_flags) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acq_scheduler.sv
// tb/tb_acq_scheduler.sv - directed and randomized check of acq_scheduler against a cycle-level reference
module tb_acq_scheduler;
  localparam int CW    = 18;
  localparam int SPP   = 4;
  localparam int PPR   = 2;
  localparam int TOTAL = SPP * PPR;
  localparam int RW    = 28;
  localparam int TMO   = 255;

  logic clk = 0;
  logic rst = 1, enable = 0, sample_tick = 0, clr_flags = 0, rd_done = 0;
  logic [CW-1:0] rd_data_1 = '0, rd_data_2 = '0;
  logic rd_start, result_valid, period_done, busy, overrun, timeout;
  logic [RW-1:0] result_1, result_2;

  int checks = 0;
  int failures = 0;
  bit mon_en = 0;

  always #5 clk = ~clk;

  acq_scheduler #(
    .CHANNEL_DATA_WIDTH(CW),
    .SAMPLES_PER_PERIOD(SPP),
    .PERIODS_PER_RESULT(PPR),
    .COUNT_WIDTH(10),
    .RESULT_WIDTH(RW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_tick(sample_tick),
    .clr_flags(clr_flags), .rd_start(rd_start), .rd_done(rd_done),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .result_1(result_1), .result_2(result_2), .result_valid(result_valid),
    .period_done(period_done), .busy(busy), .overrun(overrun), .timeout(timeout)
  );

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: scheduler described by cycle numbers of pending events
  int cyc = 0;
  bit m_on = 0;
  int m_recv = 0, m_lo = -1, m_hi = -1, m_pub = -1, m_cnt = 0;
  longint m_s1 = 0, m_s2 = 0;
  logic e_rd_start = 0, e_busy = 0, e_pd = 0, e_rv = 0, e_ov = 0, e_to = 0;
  logic [RW-1:0] e_r1 = '0, e_r2 = '0;

  always @(posedge clk) begin
    bit recv, set_ov, set_to;
    e_rd_start = 0; e_pd = 0; e_rv = 0;
    if (rst) begin
      m_on = 0; m_recv = 0; m_lo = -1; m_hi = -1; m_pub = -1; m_cnt = 0;
      m_s1 = 0; m_s2 = 0;
      e_busy = 0; e_ov = 0; e_to = 0; e_r1 = '0; e_r2 = '0;
    end else begin
      recv   = m_on && (m_hi < 0) && (m_pub < 0) && (cyc >= m_recv);
      set_ov = sample_tick && m_on && !recv;
      set_to = 0;
      if (!m_on) begin
        if (enable) begin m_on = 1; m_recv = cyc + 1; end
      end else if (recv) begin
        if (!enable) begin
          m_on = 0; m_s1 = 0; m_s2 = 0; m_cnt = 0;
        end else if (sample_tick) begin
          e_rd_start = 1; m_lo = cyc + 2; m_hi = cyc + 1 + TMO;
        end
      end else if (m_hi >= 0 && cyc >= m_lo) begin
        if (rd_done) begin
          m_s1 += int'($signed(rd_data_1));
          m_s2 += int'($signed(rd_data_2));
          m_cnt++;
          m_lo = -1; m_hi = -1;
          e_pd = (m_cnt % SPP) == 0;
          if (m_cnt == TOTAL) m_pub = cyc + 1;
          else m_recv = cyc + 2;
        end else if (cyc == m_hi) begin
          set_to = 1; m_lo = -1; m_hi = -1; m_recv = cyc + 1;
        end
      end else if (m_pub == cyc) begin
        e_rv = 1; e_r1 = RW'(m_s1); e_r2 = RW'(m_s2);
        m_s1 = 0; m_s2 = 0; m_cnt = 0; m_pub = -1; m_recv = cyc + 2;
      end
      e_busy = m_on;
      e_ov = set_ov ? 1'b1 : (clr_flags ? 1'b0 : e_ov);
      e_to = set_to ? 1'b1 : (clr_flags ? 1'b0 : e_to);
    end
    cyc++;
  end

  // Compare every output against the reference on every cycle
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rd_start", RW'(rd_start), RW'(e_rd_start));
      chk("busy", RW'(busy), RW'(e_busy));
      chk("period_done", RW'(period_done), RW'(e_pd));
      chk("result_valid", RW'(result_valid), RW'(e_rv));
      chk("overrun", RW'(overrun), RW'(e_ov));
      chk("timeout", RW'(timeout), RW'(e_to));
      chk("result_1", result_1, e_r1);
      chk("result_2", result_2, e_r2);
    end
  end

  // Event counters used by the directed literal checks
  int n_rv = 0, n_pd = 0, n_rs = 0;
  logic [RW-1:0] last_r1 = '0, last_r2 = '0;
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin n_rv++; last_r1 = result_1; last_r2 = result_2; end
    if (period_done === 1'b1) n_pd++;
    if (rd_start === 1'b1) n_rs++;
  end

  task automatic do_sample(input int dly, input logic [CW-1:0] d1, input logic [CW-1:0] d2,
                           input bit extra_tick);
    int k;
    sample_tick = 1; step(); sample_tick = 0;
    k = 0;
    while (rd_start !== 1'b1 && k < 4) begin step(); k++; end
    chk("rd_start_seen", RW'(rd_start), 1);
    if (rd_start !== 1'b1) return;
    for (int i = 0; i < dly; i++) begin
      if (extra_tick && i == 1) sample_tick = 1;
      step();
      sample_tick = 0;
    end
    rd_done = 1; rd_data_1 = d1; rd_data_2 = d2; step(); rd_done = 0;
    step(); step();
  endtask

  initial begin
    int rv0, pd0, rs0, k, pend;
    rst = 1; step(); mon_en = 1; step(); rst = 0;
    chk("reset_busy", RW'(busy), 0);
    chk("reset_result_1", result_1, 0);
    chk("reset_flags", RW'({overrun, timeout, rd_start, result_valid}), 0);

    // Nominal: +100 / -3 over 8 samples
    enable = 1; step(); step();
    rv0 = n_rv; pd0 = n_pd; rs0 = n_rs;
    for (int i = 0; i < TOTAL; i++) do_sample(5, 18'd100, 18'(-3), 0);
    chk("t1_valid_count", RW'(n_rv - rv0), 1);
    chk("t1_period_count", RW'(n_pd - pd0), 2);
    chk("t1_rd_start_count", RW'(n_rs - rs0), 8);
    chk("t1_result_1", last_r1, 28'd800);
    chk("t1_result_2", last_r2, 28'hFFFFFE8);
    chk("t1_model_r1", e_r1, 28'd800);

    // Extremes
    for (int i = 0; i < TOTAL; i++) do_sample(3, 18'h1FFFF, 18'h20000, 0);
    chk("t2_result_1", last_r1, 28'd1048568);
    chk("t2_result_2", last_r2, RW'(-1048576));

    // Overrun: tick during a read
    rv0 = n_rv; rs0 = n_rs;
    do_sample(5, 18'd2, 18'd2, 1);
    chk("t3_overrun_set", RW'(overrun), 1);
    chk("t3_one_rd_start", RW'(n_rs - rs0), 1);
    clr_flags = 1; step(); clr_flags = 0;
    chk("t3_overrun_clr", RW'(overrun), 0);
    for (int i = 1; i < TOTAL; i++) do_sample(2, 18'd2, 18'd2, 0);
    chk("t3_valid_count", RW'(n_rv - rv0), 1);
    chk("t3_result_1", last_r1, 28'd16);

    // Timeout: no rd_done
    rv0 = n_rv;
    sample_tick = 1; step(); sample_tick = 0;
    k = 0;
    while (rd_start !== 1'b1 && k < 4) begin step(); k++; end
    chk("t4_rd_start", RW'(rd_start), 1);
    k = 0;
    while (timeout !== 1'b1 && k < 300) begin step(); k++; end
    chk("t4_timeout_set", RW'(timeout), 1);
    chk("t4_timeout_latency", RW'(k), 256);
    for (int i = 0; i < TOTAL; i++) do_sample(4, 18'd3, 18'd3, 0);
    chk("t4_valid_count", RW'(n_rv - rv0), 1);
    chk("t4_result_1", last_r1, 28'd24);
    clr_flags = 1; step(); clr_flags = 0;
    chk("t4_timeout_clr", RW'(timeout), 0);

    // Disable after 3 samples discards the partial sum
    rv0 = n_rv;
    for (int i = 0; i < 3; i++) do_sample(2, 18'd9, 18'd9, 0);
    enable = 0; step(); step(); step();
    chk("t5_busy_low", RW'(busy), 0);
    chk("t5_no_valid", RW'(n_rv - rv0), 0);
    enable = 1; step(); step();
    for (int i = 0; i < TOTAL; i++) do_sample(2, 18'd1, 18'(-1), 0);
    chk("t5_result_1", last_r1, 28'd8);
    chk("t5_result_2", last_r2, 28'hFFFFFF8);

    // Reset during a read, then a late rd_done
    sample_tick = 1; step(); sample_tick = 0;
    k = 0;
    while (rd_start !== 1'b1 && k < 4) begin step(); k++; end
    step(); step();
    enable = 0; rst = 1; step(); rst = 0;
    rd_done = 1; rd_data_1 = 18'd7; rd_data_2 = 18'd7; step(); rd_done = 0;
    step();
    chk("t6_busy", RW'(busy), 0);
    chk("t6_result_1", result_1, 0);
    chk("t6_strobes", RW'({rd_start, result_valid, period_done, overrun, timeout}), 0);
    enable = 1; step(); step();
    for (int i = 0; i < TOTAL; i++) do_sample(2, 18'd5, 18'd5, 0);
    chk("t6_result_1_after", last_r1, 28'd40);

    // Randomized traffic with an engine that sometimes never answers
    pend = -1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      rst         = ($urandom_range(0, 1499) == 0);
      sample_tick = ($urandom_range(0, 3) == 0);
      clr_flags   = ($urandom_range(0, 31) == 0);
      if (rd_start === 1'b1)
        pend = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(1, 8));
      if (pend == 0) begin
        rd_done = 1; pend = -1;
      end else begin
        if (pend > 0) pend--;
        rd_done = ($urandom_range(0, 63) == 0);
      end
      rd_data_1 = 18'($urandom);
      rd_data_2 = 18'($urandom);
      step();
    end
    rst = 0; enable = 0; sample_tick = 0; rd_done = 0; clr_flags = 0;
    step(); step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
